// File: rtl/serial_mult_arb.sv
// ---------------------------------------------------------------------------
// serial_mult_arb
//
// Lets NREQ requesters share one serial 8x8 multiplier. The arbiter grants
// requesters in round-robin order and feeds the granted operand pair into the
// multiplier as two puts. It then collects the 16-bit product with a get and
// returns it on a tagged response channel. A watchdog aborts the operation if
// the multiplier never produces a result.
//
// Ports
//   clk            clock
//   rst_b          asynchronous active-low reset (shared with the multiplier)
//   req_valid      [NREQ]    per-requester request
//   req_a, req_b   [8*NREQ]  operands, requester i at bits [8i+7:8i]
//   req_ready      [NREQ]    one-hot accept strobe (combinational, IDLE only)
//   rsp_valid      response available (RESP state)
//   rsp_ready      response consumer ready
//   rsp_id         [IDW]     requester owning the response
//   rsp_data       [16]      product, 0 on abort
//   rsp_err        response was aborted by the watchdog
//   m_put/m_idata  operand stream to the multiplier
//   m_get          result acknowledge to the multiplier
//   m_ready        multiplier can take an operand
//   m_result       multiplier product
//   m_result_valid multiplier product valid
//   busy           FSM not in IDLE
//   timeout_err    sticky watchdog-abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module serial_mult_arb #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_data,
    output logic                rsp_err,
    output logic                m_put,
    output logic [7:0]          m_idata,
    output logic                m_get,
    input  logic                m_ready,
    input  logic [15:0]         m_result,
    input  logic                m_result_valid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int NPAD = 1 << IDW;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUT_A    = 3'd1,
        S_PUT_B    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            timeout_err_q, timeout_err_d;

    // Requests and operands padded out to 2**IDW entries so the grant index
    // addresses them directly; padding entries never request.
    logic [NPAD-1:0] req_pad;
    logic [7:0]      a_arr [NPAD];
    logic [7:0]      b_arr [NPAD];

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_req
            if (gi < NREQ) begin : g_real
                assign req_pad[gi] = req_valid[gi];
                assign a_arr[gi]   = req_a[8*gi +: 8];
                assign b_arr[gi]   = req_b[8*gi +: 8];
                // Gated by rst_b so the strobe is also 0 while reset is held.
                assign req_ready[gi] = rst_b && (state_q == S_IDLE) &&
                                       grant_found && (grant_idx == IDW'(gi));
            end else begin : g_pad
                assign req_pad[gi] = 1'b0;
                assign a_arr[gi]   = 8'h00;
                assign b_arr[gi]   = 8'h00;
            end
        end
    endgenerate

    // Round-robin search: start one past the last grant and wrap at NREQ.
    always_comb begin : arb_search
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && req_pad[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= S_IDLE;
            ptr_q         <= IDW'(NREQ - 1);
            gnt_q         <= '0;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            cnt_q         <= 8'h00;
            rsp_id_q      <= '0;
            rsp_data_q    <= 16'h0000;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    gnt_d   = grant_idx;
                    ptr_d   = grant_idx;
                    a_d     = a_arr[grant_idx];
                    b_d     = b_arr[grant_idx];
                    state_d = S_PUT_A;
                end
            end
            S_PUT_A: begin
                if (m_ready) begin
                    state_d = S_PUT_B;
                end
            end
            S_PUT_B: begin
                cnt_d   = 8'h00;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // A result in the final watchdog cycle still wins.
                if (m_result_valid) begin
                    rsp_data_d = m_result;
                    rsp_err_d  = 1'b0;
                    rsp_id_d   = gnt_q;
                    state_d    = S_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rsp_data_d    = 16'h0000;
                    rsp_err_d     = 1'b1;
                    rsp_id_d      = gnt_q;
                    timeout_err_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        m_put     = 1'b0;
        m_idata   = 8'h00;
        m_get     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_PUT_A: begin
                if (m_ready) begin
                    m_put   = 1'b1;
                    m_idata = a_q;
                end
            end
            S_PUT_B: begin
                m_put   = 1'b1;
                m_idata = b_q;
            end
            S_WAIT_RES: begin
                m_get = m_result_valid;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_mult_arb.sv
// ---------------------------------------------------------------------------
// Bench for serial_mult_arb. A behavioural multiplier stub sits on the m_*
// side and can stall m_ready, delay its result, or never deliver one. A
// monitor pushes an expected response on every accept and pops and compares
// it on every response handshake. Scenario tasks check timing inline.
// ---------------------------------------------------------------------------
module tb_serial_mult_arb;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              m_put;
    logic [7:0]        m_idata;
    logic              m_get;
    logic              m_ready;
    logic [15:0]       m_result;
    logic              m_result_valid;
    logic              busy;
    logic              timeout_err;

    serial_mult_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .m_put          (m_put),
        .m_idata        (m_idata),
        .m_get          (m_get),
        .m_ready        (m_ready),
        .m_result       (m_result),
        .m_result_valid (m_result_valid),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier stub ----------------
    logic        m_ready_tb = 1'b1;
    logic        stub_hang  = 1'b0;
    int          stub_dly   = 0;
    logic        stub_stage, stub_pend, stub_rv;
    logic [7:0]  stub_a;
    logic [15:0] stub_res;
    int          stub_cnt;

    assign m_ready        = m_ready_tb;
    assign m_result       = stub_res;
    assign m_result_valid = stub_rv;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stub_stage <= 1'b0;
            stub_pend  <= 1'b0;
            stub_rv    <= 1'b0;
            stub_a     <= 8'h00;
            stub_res   <= 16'h0000;
            stub_cnt   <= 0;
        end else begin
            if (m_get) stub_rv <= 1'b0;
            if (m_put) begin
                if (!stub_stage) begin
                    stub_a     <= m_idata;
                    stub_stage <= 1'b1;
                end else begin
                    stub_stage <= 1'b0;
                    stub_res   <= {8'h00, stub_a} * {8'h00, m_idata};
                    if (!stub_hang) begin
                        if (stub_dly == 0) begin
                            stub_rv <= 1'b1;
                        end else begin
                            stub_pend <= 1'b1;
                            stub_cnt  <= stub_dly;
                        end
                    end
                end
            end
            if (stub_pend) begin
                if (stub_cnt == 1) begin
                    stub_rv   <= 1'b1;
                    stub_pend <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [18:0] exp_q [$];
    int          acc_id_q [$];
    int          acc_cyc_q [$];
    logic [15:0] mon_pa, mon_pb;
    logic [18:0] mon_e;

    always @(negedge clk) begin
        #4;
        if (!rst_b) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    mon_pa = {8'h00, req_a[8*i +: 8]};
                    mon_pb = {8'h00, req_b[8*i +: 8]};
                    if (stub_hang) exp_q.push_back({2'(i), 16'h0000, 1'b1});
                    else           exp_q.push_back({2'(i), 16'(mon_pa * mon_pb), 1'b0});
                    acc_id_q.push_back(i);
                    acc_cyc_q.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: got id=%0d data=%h err=%b, want no response",
                             rsp_id, rsp_data, rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rsp_id, rsp_data, rsp_err} !== mon_e) begin
                        n_bad++;
                        $display("FAIL sb_response: got id=%0d data=%h err=%b, want id=%0d data=%h err=%b",
                                 rsp_id, rsp_data, rsp_err, mon_e[18:17], mon_e[16:1], mon_e[0]);
                    end else begin
                        $display("rsp id=%0d data=%h err=%b ok", rsp_id, rsp_data, rsp_err);
                    end
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        for (int c = 0; c < budget && !rsp_valid; c++) tick;
        ok = rsp_valid;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        for (int c = 0; c < budget && busy; c++) tick;
        ok = !busy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_b = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        tick;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, m_put, m_idata,
             m_get, busy, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d d=%h e=%b put=%b idata=%h get=%b busy=%b to=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, m_put, m_idata, m_get, busy, timeout_err);
        end
        req_valid = '0;
        tick;
        rst_b = 1'b1;
        tick;
        n_cmp++;
        if ({busy, req_ready, rsp_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got busy=%b rdy=%b v=%b, want 0",
                     busy, req_ready, rsp_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_fairness;
        bit ok;
        acc_id_q.delete();
        acc_cyc_q.delete();
        for (int i = 0; i < NREQ; i++) drive(i, 8'(8'h10 + i), 8'(8'h21 * (i + 1)));
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && acc_id_q.size() < 6; c++) tick;
        req_valid = '0;
        n_cmp++;
        if (acc_id_q.size() < 6) begin
            n_bad++;
            $display("FAIL fairness_timeout: got %0d accepts, want 6", acc_id_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (acc_id_q[k] !== (k % NREQ)) begin
                    n_bad++;
                    $display("FAIL fairness_order[%0d]: got %0d, want %0d", k, acc_id_q[k], k % NREQ);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (acc_cyc_q[k] - acc_cyc_q[k-1] !== 5) begin
                        n_bad++;
                        $display("FAIL fairness_spacing[%0d]: got %0d cycles, want 5",
                                 k, acc_cyc_q[k] - acc_cyc_q[k-1]);
                    end
                end
            end
        end
        wait_idle(20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL fairness_idle: got busy=1, want 0"); end
        $display("test_fairness done");
    endtask

    task automatic test_single;
        tick;
        drive(0, 8'h03, 8'h05);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL single_accept: got %b, want 0001", req_ready);
        end
        tick;
        req_valid = '0;
        n_cmp++;
        if ({m_put, m_idata} !== 9'h103) begin
            n_bad++; $display("FAIL single_put_a: got put=%b idata=%h, want 1/03", m_put, m_idata);
        end
        tick;
        n_cmp++;
        if ({m_put, m_idata} !== 9'h105) begin
            n_bad++; $display("FAIL single_put_b: got put=%b idata=%h, want 1/05", m_put, m_idata);
        end
        tick;
        n_cmp++;
        if ({m_get, m_put, m_idata} !== 10'h200) begin
            n_bad++; $display("FAIL single_get: got get=%b put=%b idata=%h, want 1/0/00", m_get, m_put, m_idata);
        end
        tick;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 16'h000F, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rsp: got v=%b id=%0d d=%h e=%b, want 1/0/000f/0",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        tick;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy=%b, want 0", busy); end
        $display("test_single done");
    endtask

    task automatic test_backpressure;
        bit ok;
        tick;
        drive(1, 8'hFF, 8'hFF);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL bp_accept: got %b, want 0010", req_ready);
        end
        tick;
        req_valid = '0;
        drive(3, 8'h02, 8'h03);
        wait_rsp(10, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_rsp_timeout: got rsp_valid=0, want 1"); end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_err, req_ready} !== {1'b1, 16'hFE01, 1'b0, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b, want 1/fe01/0/0000",
                         k, rsp_valid, rsp_data, rsp_err, req_ready);
            end
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        n_cmp++;
        if ({busy, req_ready} !== {1'b0, 4'b1000}) begin
            n_bad++; $display("FAIL bp_reenter_idle: got busy=%b rdy=%b, want 0/1000", busy, req_ready);
        end
        tick;
        req_valid = '0;
        wait_idle(20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_idle: got busy=1, want 0"); end
        $display("test_backpressure done");
    endtask

    task automatic test_stall;
        bit ok;
        tick;
        m_ready_tb = 1'b0;
        drive(2, 8'h12, 8'h34);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL stall_accept: got %b, want 0100", req_ready);
        end
        for (int k = 0; k < 6; k++) begin
            tick;
            req_valid = '0;
            n_cmp++;
            if ({m_put, m_idata, busy} !== {1'b0, 8'h00, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got put=%b idata=%h busy=%b, want 0/00/1", k, m_put, m_idata, busy);
            end
        end
        tick;
        m_ready_tb = 1'b1;
        #1;
        n_cmp++;
        if ({m_put, m_idata} !== 9'h112) begin
            n_bad++; $display("FAIL stall_put_a: got put=%b idata=%h, want 1/12", m_put, m_idata);
        end
        tick;
        n_cmp++;
        if ({m_put, m_idata} !== 9'h134) begin
            n_bad++; $display("FAIL stall_put_b: got put=%b idata=%h, want 1/34", m_put, m_idata);
        end
        wait_rsp(5, ok);
        n_cmp++;
        if ({ok, rsp_data, rsp_err} !== {1'b1, 16'h03A8, 1'b0}) begin
            n_bad++; $display("FAIL stall_rsp: got v=%b d=%h e=%b, want 1/03a8/0", ok, rsp_data, rsp_err);
        end
        tick;
        wait_idle(10, ok);
        $display("test_stall done");
    endtask

    task automatic test_watchdog;
        bit ok;
        int t_acc, t_rsp;
        tick;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL wd_flag_before: got %b, want 0", timeout_err);
        end
        stub_hang = 1'b1;
        drive(3, 8'h07, 8'h09);
        rsp_ready = 1'b1;
        #1;
        t_acc = cyc;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL wd_accept: got %b, want 1000", req_ready);
        end
        tick;
        req_valid = '0;
        wait_rsp(30, ok);
        t_rsp = cyc;
        n_cmp++;
        if (!ok || (t_rsp - t_acc) != 3 + TIMEOUT) begin
            n_bad++;
            $display("FAIL wd_latency: got v=%b after %0d cycles, want 1 after %0d", ok, t_rsp - t_acc, 3 + TIMEOUT);
        end
        n_cmp++;
        if ({rsp_err, rsp_data, timeout_err} !== {1'b1, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL wd_abort: got e=%b d=%h to=%b, want 1/0000/1", rsp_err, rsp_data, timeout_err);
        end
        tick;
        stub_hang = 1'b0;
        wait_idle(10, ok);
        drive(0, 8'h0B, 8'h0D);
        tick;
        req_valid = '0;
        wait_rsp(10, ok);
        n_cmp++;
        if ({ok, rsp_err, rsp_data, timeout_err} !== {1'b1, 1'b0, 16'h008F, 1'b1}) begin
            n_bad++;
            $display("FAIL wd_sticky: got v=%b e=%b d=%h to=%b, want 1/0/008f/1", ok, rsp_err, rsp_data, timeout_err);
        end
        tick;
        wait_idle(10, ok);
        $display("test_watchdog done");
    endtask

    task automatic test_boundary;
        bit ok;
        int t_acc, t_rsp;
        tick;
        stub_dly = TIMEOUT - 1;
        drive(1, 8'h21, 8'h04);
        rsp_ready = 1'b1;
        #1;
        t_acc = cyc;
        tick;
        req_valid = '0;
        wait_rsp(30, ok);
        t_rsp = cyc;
        n_cmp++;
        if ({ok, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0084} || (t_rsp - t_acc) != 3 + TIMEOUT) begin
            n_bad++;
            $display("FAIL boundary_result_wins: got v=%b e=%b d=%h after %0d, want 1/0/0084 after %0d",
                     ok, rsp_err, rsp_data, t_rsp - t_acc, 3 + TIMEOUT);
        end
        tick;
        stub_dly = 0;
        wait_idle(10, ok);
        $display("test_boundary done");
    endtask

    task automatic test_reset_mid;
        bit ok;
        tick;
        stub_hang = 1'b1;
        drive(1, 8'h05, 8'h06);
        rsp_ready = 1'b1;
        tick;
        req_valid = '0;
        tick;
        tick;
        tick;
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL rmid_in_wait: got busy=%b v=%b, want 1/0", busy, rsp_valid);
        end
        drive(2, 8'h0C, 8'h02);
        drive(0, 8'h0A, 8'h03);
        stub_hang = 1'b0;
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, m_put, m_idata,
             m_get, busy, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL rmid_async_outputs: got rdy=%b v=%b id=%0d d=%h e=%b put=%b idata=%h get=%b busy=%b to=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, m_put, m_idata, m_get, busy, timeout_err);
        end
        acc_id_q.delete();
        tick;
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL rmid_first_grant: got %b, want 0001", req_ready);
        end
        for (int c = 0; c < 20 && acc_id_q.size() < 2; c++) begin
            tick;
            if (acc_id_q.size() >= 1) req_valid[0] = 1'b0;
        end
        req_valid = '0;
        n_cmp++;
        if (acc_id_q.size() < 2 || acc_id_q[0] != 0 || acc_id_q[1] != 2) begin
            n_bad++;
            $display("FAIL rmid_order: got %0d accepts first=%0d second=%0d, want 0 then 2",
                     acc_id_q.size(), (acc_id_q.size() > 0) ? acc_id_q[0] : -1,
                     (acc_id_q.size() > 1) ? acc_id_q[1] : -1);
        end
        wait_idle(20, ok);
        tick;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_backpressure;
        test_stall;
        test_watchdog;
        test_boundary;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
